jump_motion_ctl: RTL and testbench
==================================

Name: jump_motion_ctl

Overview:
- Parametrised successor to the single-screen character controller.
- Integrates a signed velocity model for the player sprite, one step per frame tick: charge-and-release jump, walking, gravity, ceiling and wall bounce, and multi-screen level transitions.
- Sits between the keyboard decoder and the sprite/level draw blocks.
- Collision flags come from the external map-lookup block; this block owns position, velocity, state and level.

Parameters:
- SCREEN_W, 1024, screen width in px
- SCREEN_H, 768, screen height in px
- SPRITE_W, 47, sprite width in px
- SPRITE_H, 63, sprite height in px
- START_X, 488, reset x
- START_Y, 705, reset y (SCREEN_H-SPRITE_H)
- LEVELS, 4, number of stacked screens
- GRAVITY, 1, px/tick² added to vy
- MAX_FALL, 16, vy clamp, px/tick
- CHARGE_STEP, 1, charge added per tick while space held
- MAX_CHARGE, 24, charge saturation; also the initial |vy|
- WALK_SPEED, 2, px/tick on ground
- JUMP_VX, 4, |vx| of a directional jump

Ports:
- clk, in, 1, system clock
- rst_n, in, 1, asynchronous active-low reset
- tick, in, 1, one-cycle frame strobe; all state/position updates occur only on clk edges with tick=1
- key_space, in, 1, jump charge (held) / release
- key_left, in, 1, move/aim left
- key_right, in, 1, move/aim right
- collision_bot, in, 1, solid directly below sprite at current position
- collision_top, in, 1, solid directly above
- collision_left, in, 1, solid directly left
- collision_right, in, 1, solid directly right
- value_x, out, 12, sprite left edge
- value_y, out, 12, sprite top edge
- character_skin, out, 2, 0 ground, 1 charging, 2 rising, 3 falling
- facing, out, 1, 0 right, 1 left
- level, out, $clog2(LEVELS), current screen index (0 = bottom)
- jump_power, out, 5, current charge

Behaviour:
- Reset (async, rst_n=0) values:
  - value_x=START_X, value_y=START_Y
  - vx=vy=0, jump_power=0, level=0, facing=0
  - state=IDLE, skin=0
  - Reset mid-jump aborts immediately to these values.
- States: IDLE, WALK, CHARGE, RISE, FALL. Outputs are registered. Decisions use inputs sampled on the tick edge.
- IDLE/WALK:
  - Priority: key_space > key_left > key_right.
  - key_space → CHARGE with jump_power=CHARGE_STEP.
  - key_left → WALK, facing=1, x -= WALK_SPEED, unless collision_left or x < WALK_SPEED, in which case clamp x to 0 / hold x.
  - key_right mirrors key_left, with limit SCREEN_W-SPRITE_W-1.
  - No key → IDLE.
  - collision_bot=0 and not on the level-0 floor → FALL, vy=0.
- CHARGE:
  - x is held.
  - Space held: jump_power += CHARGE_STEP, saturating at MAX_CHARGE.
  - Jump launches on space release, or on the tick after saturation (auto-release):
    - vy = -jump_power
    - vx = -JUMP_VX if key_left, +JUMP_VX if key_right, 0 if neither or both
    - facing follows vx sign
    - jump_power=0, → RISE
- Airborne (RISE/FALL), per tick:
  - y += vy, then vy = min(vy+GRAVITY, MAX_FALL).
  - x += vx.
  - RISE → FALL on the tick vy becomes >0.
- Ceiling: RISE with collision_top → vy=0, FALL; y is not advanced that tick.
- Wall bounce: airborne and (collision_left with vx<0, or collision_right with vx>0, or the x step would exceed [0, SCREEN_W-SPRITE_W-1]):
  - x clamped to the limit
  - vx negated
  - facing flipped
- Landing:
  - FALL with collision_bot → IDLE; vx=vy=0; y not advanced that tick.
  - Level 0: y ≥ SCREEN_H-SPRITE_H → clamp to that value, land.
- Level up: airborne y step gives y<0.
  - level<LEVELS-1: level+1, y += SCREEN_H-SPRITE_H.
  - Top level: y=0, vy=0, → FALL.
- Level down: y > SCREEN_H-SPRITE_H with level>0 → level-1, y -= SCREEN_H-SPRITE_H.
- Arithmetic:
  - vx, vy are 7-bit signed.
  - Position math uses 13-bit signed intermediates, so there is no wrap.
  - Outputs are never outside [0, SCREEN_W-SPRITE_W-1] × [0, SCREEN_H-SPRITE_H].
- Simultaneous events:
  - Landing and wall bounce on the same tick: landing wins, vx=0.
  - Ceiling and wall on the same tick: both applied.
- Skin: IDLE/WALK→0, CHARGE→1, RISE→2, FALL→3.

Test Plan:
- Reset, 20 ticks with no keys, collision_bot=0 on level 0 → x=488, y=705, state IDLE, skin 0 throughout.
- Space held 10 ticks then released, no direction → launch vy=-10, peak y=650 after 10 ticks, lands back at y=705 with x=488; skin sequence 1→2→3→0.
- Space held 30 ticks → jump_power saturates at 24; auto-launch on the next tick with vy=-24 while space is still held.
- Right jump at x=970, charge 8 → on the tick the x step would exceed 976, x=976, vx=-4, facing=1; sprite continues leftward.
- Max jump from y=60 on level 0 → y crosses 0, level=1, y wraps near 705; subsequent fall past the bottom with no floor returns level=0.
- rst_n pulsed low mid-RISE, asynchronously between clk edges → outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/jump_motion_ctl.sv
// Player sprite motion controller: charge-and-release jump, walking, gravity,
// ceiling/wall bounce and stacked-screen level transitions, one step per frame tick.
module jump_motion_ctl #(
    parameter int SCREEN_W    = 1024,
    parameter int SCREEN_H    = 768,
    parameter int SPRITE_W    = 47,
    parameter int SPRITE_H    = 63,
    parameter int START_X     = 488,
    parameter int START_Y     = 705,
    parameter int LEVELS      = 4,
    parameter int GRAVITY     = 1,
    parameter int MAX_FALL    = 16,
    parameter int CHARGE_STEP = 1,
    parameter int MAX_CHARGE  = 24,
    parameter int WALK_SPEED  = 2,
    parameter int JUMP_VX     = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       tick,
    input  logic                       key_space,
    input  logic                       key_left,
    input  logic                       key_right,
    input  logic                       collision_bot,
    input  logic                       collision_top,
    input  logic                       collision_left,
    input  logic                       collision_right,
    output logic [11:0]                value_x,
    output logic [11:0]                value_y,
    output logic [1:0]                 character_skin,
    output logic                       facing,
    output logic [$clog2(LEVELS)-1:0]  level,
    output logic [4:0]                 jump_power
);

    localparam int LVL_W = $clog2(LEVELS);

    localparam logic signed [12:0] X_MAX_S       = 13'(SCREEN_W - SPRITE_W - 1);
    localparam logic signed [12:0] Y_MAX_S       = 13'(SCREEN_H - SPRITE_H);
    localparam logic [11:0]        X_MAX_U       = 12'(SCREEN_W - SPRITE_W - 1);
    localparam logic [11:0]        Y_MAX_U       = 12'(SCREEN_H - SPRITE_H);
    localparam logic [11:0]        START_X_U     = 12'(START_X);
    localparam logic [11:0]        START_Y_U     = 12'(START_Y);
    localparam logic [11:0]        WALK_U        = 12'(WALK_SPEED);
    localparam logic signed [6:0]  JUMP_VX_S     = 7'(JUMP_VX);
    localparam logic signed [7:0]  GRAV_S8       = 8'(GRAVITY);
    localparam logic signed [7:0]  MAX_FALL_S8   = 8'(MAX_FALL);
    localparam logic [4:0]         CHARGE_STEP_U = 5'(CHARGE_STEP);
    localparam logic [4:0]         MAX_CHARGE_U  = 5'(MAX_CHARGE);
    localparam logic [LVL_W-1:0]   TOP_LEVEL     = LVL_W'(LEVELS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WALK   = 3'd1,
        CHARGE = 3'd2,
        RISE   = 3'd3,
        FALL   = 3'd4
    } state_t;

    state_t            state, nxt_state;
    logic signed [6:0] vx, vy, nxt_vx, nxt_vy;
    logic [11:0]       nxt_x, nxt_y;
    logic              nxt_face;
    logic [LVL_W-1:0]  nxt_level;
    logic [4:0]        nxt_power;

    logic signed [12:0] x_s, y_s, nx, ny;
    logic signed [7:0]  vy_sum;
    logic signed [6:0]  vy_grav;
    logic [12:0]        walk_r_sum;
    logic [5:0]         charge_sum;
    logic               on_floor;
    logic               hit_wall;

    function automatic logic [1:0] skin_of(input state_t s);
        case (s)
            CHARGE:  return 2'd1;
            RISE:    return 2'd2;
            FALL:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    // Widened signed intermediates keep the position step free of wrap-around.
    always_comb begin
        x_s        = $signed({1'b0, value_x});
        y_s        = $signed({1'b0, value_y});
        nx         = x_s + 13'(vx);
        ny         = y_s + 13'(vy);
        vy_sum     = 8'(vy) + GRAV_S8;
        vy_grav    = (vy_sum > MAX_FALL_S8) ? MAX_FALL_S8[6:0] : vy_sum[6:0];
        walk_r_sum = {1'b0, value_x} + {1'b0, WALK_U};
        charge_sum = {1'b0, jump_power} + {1'b0, CHARGE_STEP_U};
        on_floor   = (level == '0) && (value_y == Y_MAX_U);
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        nxt_state = state;
        nxt_x     = value_x;
        nxt_y     = value_y;
        nxt_vx    = vx;
        nxt_vy    = vy;
        nxt_face  = facing;
        nxt_level = level;
        nxt_power = jump_power;
        hit_wall  = 1'b0;

        case (state)
            IDLE, WALK: begin
                if (!collision_bot && !on_floor) begin
                    nxt_state = FALL;
                    nxt_vx    = '0;
                    nxt_vy    = '0;
                end else if (key_space) begin
                    nxt_state = CHARGE;
                    nxt_power = CHARGE_STEP_U;
                end else if (key_left) begin
                    nxt_state = WALK;
                    nxt_face  = 1'b1;
                    if (!collision_left)
                        nxt_x = (value_x < WALK_U) ? '0 : value_x - WALK_U;
                end else if (key_right) begin
                    nxt_state = WALK;
                    nxt_face  = 1'b0;
                    if (!collision_right)
                        nxt_x = (walk_r_sum > {1'b0, X_MAX_U}) ? X_MAX_U : walk_r_sum[11:0];
                end else begin
                    nxt_state = IDLE;
                end
            end

            CHARGE: begin
                // Launch on release, or one tick after the charge has saturated.
                if (!key_space || jump_power >= MAX_CHARGE_U) begin
                    nxt_state = RISE;
                    nxt_vy    = 7'sd0 - $signed({2'b00, jump_power});
                    nxt_power = '0;
                    if (key_left && !key_right) begin
                        nxt_vx   = 7'sd0 - JUMP_VX_S;
                        nxt_face = 1'b1;
                    end else if (key_right && !key_left) begin
                        nxt_vx   = JUMP_VX_S;
                        nxt_face = 1'b0;
                    end else begin
                        nxt_vx = '0;
                    end
                end else begin
                    nxt_power = (charge_sum >= {1'b0, MAX_CHARGE_U}) ? MAX_CHARGE_U : charge_sum[4:0];
                end
            end

            RISE, FALL: begin
                if (state == FALL && collision_bot) begin
                    nxt_state = IDLE;
                    nxt_vx    = '0;
                    nxt_vy    = '0;
                end else begin
                    hit_wall = 1'b1;
                    if ((collision_left && vx < 7'sd0) || (collision_right && vx > 7'sd0))
                        nxt_x = value_x;
                    else if (nx < 13'sd0)
                        nxt_x = '0;
                    else if (nx > X_MAX_S)
                        nxt_x = X_MAX_U;
                    else begin
                        nxt_x    = nx[11:0];
                        hit_wall = 1'b0;
                    end
                    if (hit_wall) begin
                        nxt_vx   = 7'sd0 - vx;
                        nxt_face = ~facing;
                    end

                    if (state == RISE && collision_top) begin
                        nxt_vy    = '0;
                        nxt_state = FALL;
                    end else begin
                        nxt_vy = vy_grav;
                        if (state == RISE && vy_grav > 7'sd0)
                            nxt_state = FALL;
                        if (ny < 13'sd0) begin
                            if (level != TOP_LEVEL) begin
                                nxt_level = level + 1'b1;
                                nxt_y     = 12'(ny + Y_MAX_S);
                            end else begin
                                nxt_y     = '0;
                                nxt_vy    = '0;
                                nxt_state = FALL;
                            end
                        end else if (ny >= Y_MAX_S && level == '0) begin
                            // Floor landing overrides any bounce taken this tick.
                            nxt_y     = Y_MAX_U;
                            nxt_state = IDLE;
                            nxt_vx    = '0;
                            nxt_vy    = '0;
                            nxt_face  = facing;
                        end else if (ny > Y_MAX_S) begin
                            nxt_level = level - 1'b1;
                            nxt_y     = 12'(ny - Y_MAX_S);
                        end else begin
                            nxt_y = ny[11:0];
                        end
                    end
                end
            end

            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            value_x        <= START_X_U;
            value_y        <= START_Y_U;
            vx             <= '0;
            vy             <= '0;
            jump_power     <= '0;
            level          <= '0;
            facing         <= 1'b0;
            character_skin <= 2'd0;
        end else if (tick) begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state          <= nxt_state;
            value_x        <= nxt_x;
            value_y        <= nxt_y;
            vx             <= nxt_vx;
            vy             <= nxt_vy;
            jump_power     <= nxt_power;
            level          <= nxt_level;
            facing         <= nxt_face;
            character_skin <= skin_of(nxt_state);
        end
    end

endmodule

// File: tb/tb_jump_motion_ctl.sv
// Scoreboard bench for jump_motion_ctl: each tick pushes its hand-computed
// expectation; a monitor pops and compares after the tick edge.
module tb_jump_motion_ctl;

    localparam int NA = -1;

    typedef struct {
        string name;
        int    x;
        int    y;
        int    skin;
        int    face;
        int    lvl;
        int    pow;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        key_space, key_left, key_right;
    logic        collision_bot, collision_top, collision_left, collision_right;
    logic [11:0] value_x, value_y;
    logic [1:0]  character_skin;
    logic        facing;
    logic [1:0]  level;
    logic [4:0]  jump_power;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic tick_seen = 1'b0;

    int t2_y [21] = '{695, 686, 678, 671, 665, 660, 656, 653, 651, 650,
                      650, 651, 653, 656, 660, 665, 671, 678, 686, 695, 705};
    int t2_s [21] = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2,
                      3, 3, 3, 3, 3, 3, 3, 3, 3, 3, 0};

    jump_motion_ctl dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .tick            (tick),
        .key_space       (key_space),
        .key_left        (key_left),
        .key_right       (key_right),
        .collision_bot   (collision_bot),
        .collision_top   (collision_top),
        .collision_left  (collision_left),
        .collision_right (collision_right),
        .value_x         (value_x),
        .value_y         (value_y),
        .character_skin  (character_skin),
        .facing          (facing),
        .level           (level),
        .jump_power      (jump_power)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic exp_t ex(input string n, input int x, input int y, input int skin,
                                input int face, input int lvl, input int pow);
        exp_t e;
        e.name = n; e.x = x; e.y = y; e.skin = skin; e.face = face; e.lvl = lvl; e.pow = pow;
        return e;
    endfunction

    task automatic step(input exp_t e);
        @(negedge clk);
        tick = 1'b1;
        sb.push_back(e);
        @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(ex("", NA, NA, NA, NA, NA, NA));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".x"},    int'(value_x), 488);
        check({tag, ".y"},    int'(value_y), 705);
        check({tag, ".skin"}, int'(character_skin), 0);
        check({tag, ".face"}, int'(facing), 0);
        check({tag, ".lvl"},  int'(level), 0);
        check({tag, ".pow"},  int'(jump_power), 0);
    endtask

    always @(posedge clk) tick_seen <= tick;

    // Monitor: one scoreboard entry is consumed per tick the DUT accepted.
    always @(negedge clk) begin
        if (tick_seen) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: tick with no expectation queued");
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.x    >= 0) check({mon_e.name, ".x"},    int'(value_x), mon_e.x);
                if (mon_e.y    >= 0) check({mon_e.name, ".y"},    int'(value_y), mon_e.y);
                if (mon_e.skin >= 0) check({mon_e.name, ".skin"}, int'(character_skin), mon_e.skin);
                if (mon_e.face >= 0) check({mon_e.name, ".face"}, int'(facing), mon_e.face);
                if (mon_e.lvl  >= 0) check({mon_e.name, ".lvl"},  int'(level), mon_e.lvl);
                if (mon_e.pow  >= 0) check({mon_e.name, ".pow"},  int'(jump_power), mon_e.pow);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; tick = 1'b0;
        key_space = 1'b0; key_left = 1'b0; key_right = 1'b0;
        collision_bot = 1'b0; collision_top = 1'b0;
        collision_left = 1'b0; collision_right = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // No keys, no ground flag, on the level-0 floor: stays put.
        for (int i = 0; i < 20; i++) step(ex("idle", 488, 705, 0, 0, 0, 0));

        // Charge 10, release, vertical arc with peak 650.
        key_space = 1'b1;
        for (int k = 1; k <= 10; k++) step(ex("charge10", 488, 705, 1, 0, 0, k));
        key_space = 1'b0;
        step(ex("launch10", 488, 705, 2, 0, 0, 0));
        for (int a = 0; a < 21; a++) step(ex("arc10", 488, t2_y[a], t2_s[a], 0, 0, 0));

        // Saturating charge and auto-launch while space stays held.
        key_space = 1'b1;
        for (int k = 1; k <= 24; k++) step(ex("charge_sat", NA, 705, 1, NA, NA, k));
        step(ex("auto_launch", 488, 705, 2, 0, 0, 0));
        step(ex("vy24_a1", NA, 681, 2, NA, NA, NA));
        step(ex("vy24_a2", NA, 658, 2, NA, NA, NA));
        run(3);
        key_space = 1'b0;
        run(45);
        step(ex("max_a51", 488, 701, 3, 0, 0, 0));
        step(ex("max_land", 488, 705, 0, 0, 0, 0));

        // Walking: left wins over right, then walk right to x=970.
        key_left = 1'b1; key_right = 1'b1;
        step(ex("walk_prio", 486, 705, 0, 1, 0, 0));
        key_left = 1'b0;
        step(ex("walk_right", 488, 705, 0, 0, 0, 0));
        run(240);
        step(ex("walk_970", 970, 705, 0, 0, 0, 0));

        // Right jump bounces off the right screen limit.
        key_space = 1'b1;
        for (int k = 1; k <= 8; k++) step(ex("charge8", 970, 705, 1, 0, 0, k));
        key_space = 1'b0;
        step(ex("launch_r", 970, 705, 2, 0, 0, 0));
        step(ex("jr_a1", 974, 697, 2, 0, 0, NA));
        step(ex("jr_bounce", 976, 690, 2, 1, 0, NA));
        key_right = 1'b0;
        step(ex("jr_a3", 972, 684, 2, 1, 0, NA));
        run(12);
        step(ex("jr_a16", 920, 697, 3, 1, 0, NA));
        step(ex("jr_land", NA, 705, 0, 1, 0, 0));

        // Climb on platforms: land at each peak via collision_bot.
        collision_bot = 1'b1;
        key_space = 1'b1;
        run(24);
        step(ex("c1_launch", NA, 705, 2, NA, 0, 0));
        key_space = 1'b0;
        run(24);
        step(ex("c1_peak", NA, 405, 3, NA, 0, NA));
        step(ex("c1_land", NA, 405, 0, NA, 0, 0));
        key_space = 1'b1;
        run(24);
        step(ex("c2_launch", NA, 405, 2, NA, 0, 0));
        key_space = 1'b0;
        run(24);
        step(ex("c2_peak", NA, 105, 3, NA, 0, NA));
        step(ex("c2_land", NA, 105, 0, NA, 0, 0));
        key_space = 1'b1;
        run(8);
        step(ex("c3_pow9", NA, 105, 1, NA, 0, 9));
        key_space = 1'b0;
        step(ex("c3_launch", NA, 105, 2, NA, 0, 0));
        run(8);
        step(ex("c3_top", NA, 60, 2, NA, 0, NA));
        step(ex("c3_fall", NA, 60, 3, NA, 0, NA));
        step(ex("c3_land", NA, 60, 0, NA, 0, 0));

        // Max jump from y=60 crosses into level 1, then falls back to level 0.
        key_space = 1'b1;
        run(24);
        collision_bot = 1'b0;
        step(ex("lv_launch", NA, 60, 2, NA, 0, 0));
        key_space = 1'b0;
        step(ex("lv_a1", NA, 36, 2, NA, 0, NA));
        step(ex("lv_a2", NA, 13, 2, NA, 0, NA));
        step(ex("lv_up", NA, 696, 2, NA, 1, NA));
        run(44);
        step(ex("lv_down", NA, 8, 3, NA, 0, NA));
        run(42);
        step(ex("lv_a91", NA, 696, 3, NA, 0, NA));
        step(ex("lv_land", NA, 705, 0, NA, 0, 0));

        // Ceiling hit on the first airborne tick.
        key_space = 1'b1;
        step(ex("cl_pow", NA, 705, 1, NA, 0, 1));
        key_space = 1'b0;
        step(ex("cl_launch", NA, 705, 2, NA, 0, 0));
        collision_top = 1'b1;
        step(ex("ceil", NA, 705, 3, NA, 0, NA));
        collision_top = 1'b0;
        step(ex("ceil_land", NA, 705, 0, NA, 0, NA));

        // Asynchronous reset in the middle of a rise.
        key_space = 1'b1;
        run(9);
        step(ex("ar_pow10", NA, 705, 1, NA, 0, 10));
        key_space = 1'b0;
        step(ex("ar_launch", NA, 705, 2, NA, 0, 0));
        run(2);
        step(ex("pre_rst", NA, 678, 2, 1, 0, 0));
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(ex("post_rst", 488, 705, 0, 0, 0, 0));

        repeat (2) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
